ex_operand_stage: RTL and testbench



---
 rtl/core_pkg.sv | 28 ++
 rtl/ex_operand_stage_if.sv | 70 +++++++
 rtl/ex_operand_stage_fwd_mux.sv | 39 +++
 rtl/ex_operand_stage.sv | 132 +++++++++++++
 tb/tb_ex_operand_stage.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared RV32 core types: ALU op codes and datapath widths.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package core_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    // ALU op codes shared by the decoder, the operand stage and the ALU.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRS  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_USLT = 4'b1001
    } alu_ctrl_t;

    // Shift ops only look at the low five bits of the B operand.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRS);
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Bundle of the ID->EX handshake, the forwarding sources and the ALU-side outputs.
// Latency: n/a (wires only).
// Backpressure: id_valid/id_ready upstream, ex_valid/ex_ready downstream.
interface ex_operand_stage_if #(
    parameter int XLEN = core_pkg::XLEN,
    parameter int REGW = core_pkg::REGW
);
    logic            flush;

    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic [3:0]      id_alu_ctrl;
    logic            id_src_a_pc;
    logic            id_src_b_imm;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;

    logic [REGW-1:0] exm_rd;
    logic            exm_reg_write;
    logic            exm_mem_read;
    logic            exm_valid;
    logic [XLEN-1:0] exm_result;

    logic [REGW-1:0] wb_rd;
    logic            wb_reg_write;
    logic            wb_valid;
    logic [XLEN-1:0] wb_data;

    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] alu_x;
    logic [XLEN-1:0] alu_y;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_store_data;
    logic [REGW-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;

    // Environment side: decoder, later pipeline stages and the ALU consumer.
    modport master (
        output flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_ctrl, id_src_a_pc, id_src_b_imm,
               id_reg_write, id_mem_read, id_mem_write,
               exm_rd, exm_reg_write, exm_mem_read, exm_valid, exm_result,
               wb_rd, wb_reg_write, wb_valid, wb_data, ex_ready,
        input  id_ready, ex_valid, alu_x, alu_y, alu_ctrl, ex_pc, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
    );

    // Operand stage side.
    modport slave (
        input  flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_ctrl, id_src_a_pc, id_src_b_imm,
               id_reg_write, id_mem_read, id_mem_write,
               exm_rd, exm_reg_write, exm_mem_read, exm_valid, exm_result,
               wb_rd, wb_reg_write, wb_valid, wb_data, ex_ready,
        output id_ready, ex_valid, alu_x, alu_y, alu_ctrl, ex_pc, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
    );
endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-source RAW bypass: picks EX/MEM result, then MEM/WB data, then regfile data.
// Latency: combinational.
// Backpressure: none; a load in EX/MEM is never a bypass source (data not ready yet).
module fwd_mux
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN,
    parameter int REGW = core_pkg::REGW
) (
    input  logic [REGW-1:0] rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            exm_valid,
    input  logic            exm_reg_write,
    input  logic            exm_mem_read,
    input  logic [REGW-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_valid,
    input  logic            wb_reg_write,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data
);

    logic exm_hit;
    logic wb_hit;

    // x0 never forwards; the younger EX/MEM producer beats MEM/WB.
    always_comb begin
        exm_hit  = exm_valid && exm_reg_write && !exm_mem_read && (exm_rd == rs) && (rs != '0);
        wb_hit   = wb_valid && wb_reg_write && (wb_rd == rs) && (rs != '0);
        fwd_data = rf_data;
        if (exm_hit) begin
            fwd_data = exm_result;
        end else if (wb_hit) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID->EX slot with operand forwarding, operand select and load-use bubble insertion.
// Latency: one cycle (registered slot, combinational forward/select behind it).
// Backpressure: slot holds while ex_valid && !ex_ready; id_ready drops on stall, load-use hazard or flush.
module ex_operand_stage
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN,
    parameter int REGW = core_pkg::REGW
) (
    input logic               clk,
    input logic               rst,
    ex_operand_stage_if.slave io
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [3:0]      alu_ctrl;
        logic            src_a_pc;
        logic            src_b_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } slot_t;

    slot_t           slot;
    slot_t           incoming;
    logic            slot_valid;
    logic            advance;
    logic            hazard;
    logic            accept;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    // The slot can take new work when empty or when its occupant leaves this cycle.
    assign advance = !slot_valid || io.ex_ready;

    // A load in the slot cannot feed the next instruction until it reaches WB,
    // so any source match stalls, whatever the operand selects say.
    assign hazard = slot_valid && slot.mem_read && (slot.rd != '0) &&
                    ((io.id_rs1 == slot.rd) || (io.id_rs2 == slot.rd));

    assign io.id_ready = advance && !hazard && !io.flush && !rst;
    assign accept      = io.id_valid && io.id_ready;

    assign incoming = '{
        pc:        io.id_pc,
        rs1_data:  io.id_rs1_data,
        rs2_data:  io.id_rs2_data,
        imm:       io.id_imm,
        rs1:       io.id_rs1,
        rs2:       io.id_rs2,
        rd:        io.id_rd,
        alu_ctrl:  io.id_alu_ctrl,
        src_a_pc:  io.id_src_a_pc,
        src_b_imm: io.id_src_b_imm,
        reg_write: io.id_reg_write,
        mem_read:  io.id_mem_read,
        mem_write: io.id_mem_write
    };

    // Slot register: reset and flush clear it outright; otherwise load, bubble or hold.
    always_ff @(posedge clk) begin
        if (rst || io.flush) begin
            slot_valid <= 1'b0;
            slot       <= '0;
        end else if (advance) begin
            slot_valid <= accept;
            if (accept) begin
                slot <= incoming;
            end
        end
    end

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
        .rs            (slot.rs1),
        .rf_data       (slot.rs1_data),
        .exm_valid     (io.exm_valid),
        .exm_reg_write (io.exm_reg_write),
        .exm_mem_read  (io.exm_mem_read),
        .exm_rd        (io.exm_rd),
        .exm_result    (io.exm_result),
        .wb_valid      (io.wb_valid),
        .wb_reg_write  (io.wb_reg_write),
        .wb_rd         (io.wb_rd),
        .wb_data       (io.wb_data),
        .fwd_data      (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
        .rs            (slot.rs2),
        .rf_data       (slot.rs2_data),
        .exm_valid     (io.exm_valid),
        .exm_reg_write (io.exm_reg_write),
        .exm_mem_read  (io.exm_mem_read),
        .exm_rd        (io.exm_rd),
        .exm_result    (io.exm_result),
        .wb_valid      (io.wb_valid),
        .wb_reg_write  (io.wb_reg_write),
        .wb_rd         (io.wb_rd),
        .wb_data       (io.wb_data),
        .fwd_data      (fwd_rs2)
    );

    // Operand select; shifts see only the shift amount on the B side.
    always_comb begin
        op_a = slot.src_a_pc ? slot.pc : fwd_rs1;
        op_b = slot.src_b_imm ? slot.imm : fwd_rs2;
        io.alu_x = op_a;
        io.alu_y = op_b;
        if (is_shift(slot.alu_ctrl)) begin
            io.alu_y = {{(XLEN-5){1'b0}}, op_b[4:0]};
        end
    end

    assign io.alu_ctrl      = slot.alu_ctrl;
    assign io.ex_valid      = slot_valid;
    assign io.ex_pc         = slot.pc;
    assign io.ex_store_data = fwd_rs2;
    assign io.ex_rd         = slot.rd;
    assign io.ex_reg_write  = slot.reg_write;
    assign io.ex_mem_read   = slot.mem_read;
    assign io.ex_mem_write  = slot.mem_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed corner cases, then a random instruction stream
// whose operands are predicted from in-order program semantics (value of latest older writer).
// Back end (EX/MEM, MEM/WB, regfile) is modelled by the bench and stalls with ex_ready.
module tb_ex_operand_stage;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ex_operand_stage_if bus ();

    ex_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
        logic        a_pc;
        logic        b_imm;
        logic        rw;
        logic        mr;
        logic        mw;
    } ins_t;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic        mr;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] junk;
    } bk_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic ins_t mk(input logic [3:0] ctrl, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm,
                                input logic a_pc, input logic b_imm, input logic rw, input logic mr,
                                input logic mw);
        ins_t t;
        t = '{pc: pc, imm: imm, rs1: rs1, rs2: rs2, rd: rd, ctrl: ctrl,
              a_pc: a_pc, b_imm: b_imm, rw: rw, mr: mr, mw: mw};
        return t;
    endfunction

    task automatic drive_id(input ins_t t, input logic [31:0] d1, input logic [31:0] d2);
        bus.id_pc        = t.pc;
        bus.id_imm       = t.imm;
        bus.id_rs1       = t.rs1;
        bus.id_rs2       = t.rs2;
        bus.id_rd        = t.rd;
        bus.id_alu_ctrl  = t.ctrl;
        bus.id_src_a_pc  = t.a_pc;
        bus.id_src_b_imm = t.b_imm;
        bus.id_reg_write = t.rw;
        bus.id_mem_read  = t.mr;
        bus.id_mem_write = t.mw;
        bus.id_rs1_data  = d1;
        bus.id_rs2_data  = d2;
    endtask

    task automatic drive_back(input bk_t e, input bk_t w);
        bus.exm_valid     = e.v;
        bus.exm_reg_write = e.rw;
        bus.exm_mem_read  = e.mr;
        bus.exm_rd        = e.rd;
        bus.exm_result    = e.mr ? e.junk : e.res;
        bus.wb_valid      = w.v;
        bus.wb_reg_write  = w.rw;
        bus.wb_rd         = w.rd;
        bus.wb_data       = w.res;
    endtask

    task automatic clear_bus();
        drive_id('0, 32'h0, 32'h0);
        drive_back('0, '0);
        bus.id_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ex_valid"}, bus.ex_valid, 0);
        chk({tag, "_id_ready"}, bus.id_ready, 0);
        chk({tag, "_alu_x"}, bus.alu_x, 0);
        chk({tag, "_alu_y"}, bus.alu_y, 0);
        chk({tag, "_alu_ctrl"}, bus.alu_ctrl, ALU_ADD);
        chk({tag, "_store"}, bus.ex_store_data, 0);
        chk({tag, "_pc"}, bus.ex_pc, 0);
        chk({tag, "_rd"}, bus.ex_rd, 0);
        chk({tag, "_ctl"}, {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 0);
    endtask

    function automatic ins_t rand_ins();
        ins_t t;
        t.pc    = $urandom & 32'hFFFF_FFFC;
        t.imm   = $urandom;
        t.rs1   = 5'($urandom_range(7));
        t.rs2   = 5'($urandom_range(7));
        t.rd    = 5'($urandom_range(7));
        t.ctrl  = 4'($urandom_range(15));
        t.a_pc  = ($urandom_range(3) == 0);
        t.b_imm = ($urandom_range(2) == 0);
        t.mr    = ($urandom_range(3) == 0);
        t.rw    = t.mr || ($urandom_range(4) != 0);
        t.mw    = !t.mr && ($urandom_range(5) == 0);
        return t;
    endfunction

    // Reference state for the random phase.
    logic [31:0] arch [32];   // committed register file
    logic [31:0] prog [32];   // value of the latest executed writer, in program order
    bk_t         exm_m;
    bk_t         wb_m;
    ins_t        q[$];        // instruction expected in the EX slot
    ins_t        pend;
    bit          have_pend;

    function automatic logic [31:0] rf_read(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (wb_m.v && wb_m.rw && wb_m.rd == r) return wb_m.res;   // write-before-read regfile
        return arch[r];
    endfunction

    function automatic logic [31:0] prog_val(input logic [4:0] r);
        return (r == 5'd0) ? 32'h0 : prog[r];
    endfunction

    initial begin
        ins_t s;
        bk_t  nxt;
        logic [31:0] a, b, res;
        bit   rdy, fl, haz, exp_rdy, fire, acc, hit;

        // ---------------- reset ----------------
        clear_bus();
        bus.id_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("rst");

        // ---------------- basic ADD ----------------
        @(posedge clk); #1;
        rst = 1'b0;
        drive_id(mk(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'h10, 32'h0, 0, 0, 1, 0, 0), 32'd10, 32'd20);
        bus.id_valid = 1'b1;
        @(posedge clk); #1;
        bus.id_valid = 1'b0;
        @(negedge clk);
        chk("add_ex_valid", bus.ex_valid, 1);
        chk("add_alu_x", bus.alu_x, 10);
        chk("add_alu_y", bus.alu_y, 20);
        chk("add_alu_ctrl", bus.alu_ctrl, ALU_ADD);

        // ---------------- forwarding priority ----------------
        @(posedge clk); #1;
        drive_id(mk(ALU_ADD, 5'd5, 5'd0, 5'd6, 32'h0, 32'h0, 0, 0, 1, 0, 0), 32'h11, 32'h0);
        bus.id_valid = 1'b1;
        @(posedge clk); #1;
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b0;
        drive_back('{v: 1, rw: 1, mr: 0, rd: 5'd5, res: 32'h100, junk: 32'h0},
                   '{v: 1, rw: 1, mr: 0, rd: 5'd5, res: 32'h200, junk: 32'h0});
        @(negedge clk);
        chk("fwd_exm_prio", bus.alu_x, 32'h100);
        bus.exm_valid = 1'b0;
        #1 chk("fwd_wb", bus.alu_x, 32'h200);
        bus.wb_valid = 1'b0;
        #1 chk("fwd_rf", bus.alu_x, 32'h11);
        bus.ex_ready = 1'b1;
        drive_id(mk(ALU_ADD, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 0, 0, 1, 0, 0), 32'h0, 32'h0);
        bus.id_valid = 1'b1;
        drive_back('{v: 1, rw: 1, mr: 0, rd: 5'd0, res: 32'h100, junk: 32'h0},
                   '{v: 1, rw: 1, mr: 0, rd: 5'd0, res: 32'h200, junk: 32'h0});
        @(posedge clk); #1;
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b0;
        @(negedge clk);
        chk("fwd_x0_alu_x", bus.alu_x, 0);
        chk("fwd_x0_store", bus.ex_store_data, 0);

        // ---------------- load-use ----------------
        drive_back('0, '0);
        bus.ex_ready = 1'b1;
        drive_id(mk(ALU_ADD, 5'd1, 5'd0, 5'd7, 32'h20, 32'h4, 0, 1, 1, 1, 0), 32'h1000, 32'h0);
        bus.id_valid = 1'b1;
        @(posedge clk); #1;
        drive_id(mk(ALU_SUB, 5'd2, 5'd7, 5'd8, 32'h24, 32'h0, 0, 0, 1, 0, 0), 32'h30, 32'hDEAD);
        @(negedge clk);
        chk("lu_stall_ready", bus.id_ready, 0);
        chk("lu_load_valid", bus.ex_valid, 1);
        @(posedge clk); #1;
        drive_back('{v: 1, rw: 1, mr: 1, rd: 5'd7, res: 32'h55, junk: 32'hBAD}, '0);
        @(negedge clk);
        chk("lu_bubble", bus.ex_valid, 0);
        chk("lu_resume_ready", bus.id_ready, 1);
        @(posedge clk); #1;
        bus.id_valid = 1'b0;
        drive_back('0, '{v: 1, rw: 1, mr: 0, rd: 5'd7, res: 32'h55, junk: 32'h0});
        @(negedge clk);
        chk("lu_dep_valid", bus.ex_valid, 1);
        chk("lu_wb_alu_y", bus.alu_y, 32'h55);
        chk("lu_wb_store", bus.ex_store_data, 32'h55);
        chk("lu_alu_x", bus.alu_x, 32'h30);
        chk("lu_ctrl", bus.alu_ctrl, ALU_SUB);

        // ---------------- shift immediate masking ----------------
        @(posedge clk); #1;
        drive_back('0, '0);
        drive_id(mk(ALU_SLL, 5'd1, 5'd3, 5'd4, 32'h0, 32'h24, 0, 1, 1, 0, 0), 32'h1, 32'h77);
        bus.id_valid = 1'b1;
        @(posedge clk); #1;
        drive_id(mk(ALU_ADD, 5'd1, 5'd3, 5'd4, 32'h0, 32'h24, 0, 1, 1, 0, 0), 32'h1, 32'h77);
        @(negedge clk);
        chk("sll_alu_y", bus.alu_y, 32'h4);
        chk("sll_ctrl", bus.alu_ctrl, ALU_SLL);
        chk("sll_store", bus.ex_store_data, 32'h77);
        @(posedge clk); #1;
        bus.id_valid = 1'b0;
        @(negedge clk);
        chk("addi_alu_y", bus.alu_y, 32'h24);

        // ---------------- downstream stall, then flush ----------------
        @(posedge clk); #1;
        drive_id(mk(ALU_OR, 5'd1, 5'd2, 5'd9, 32'h40, 32'h0, 0, 0, 1, 0, 0), 32'h33, 32'h44);
        bus.id_valid = 1'b1;
        @(posedge clk); #1;
        bus.ex_ready = 1'b0;
        drive_id(mk(ALU_XOR, 5'd3, 5'd4, 5'd9, 32'h80, 32'h0, 0, 0, 1, 0, 0), 32'h99, 32'h98);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", bus.id_ready, 0);
            chk("stall_alu_x", bus.alu_x, 32'h33);
            chk("stall_pc", bus.ex_pc, 32'h40);
        end
        bus.flush = 1'b1;
        #1 chk("flush_ready", bus.id_ready, 0);
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_gone", bus.ex_valid, 0);
        end

        // ---------------- reset while stalled ----------------
        @(posedge clk); #1;
        drive_id(mk(ALU_AND, 5'd1, 5'd2, 5'd10, 32'h90, 32'h0, 0, 0, 1, 0, 1), 32'h5, 32'h6);
        bus.id_valid = 1'b1;
        @(posedge clk); #1;
        bus.ex_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", bus.ex_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_state("rst_stall");
        rst = 1'b0;
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b1;
        @(negedge clk);
        chk("rst_no_survive", bus.ex_valid, 0);

        // ---------------- random stream ----------------
        clear_bus();
        rst = 1'b1;
        for (int r = 0; r < 32; r++) begin
            arch[r] = (r == 0) ? 32'h0 : $urandom;
            prog[r] = arch[r];
        end
        exm_m = '0;
        wb_m  = '0;
        q.delete();
        pend      = rand_ins();
        have_pend = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            rdy = (exm_m.v && exm_m.mr) || ($urandom_range(3) != 0);
            fl  = !(exm_m.v && exm_m.mr) && ($urandom_range(19) == 0);
            if (fl) rdy = 0;
            if (!have_pend && $urandom_range(3) != 0) begin
                pend      = rand_ins();
                have_pend = 1;
            end
            drive_id(pend, rf_read(pend.rs1), rf_read(pend.rs2));
            bus.id_valid = have_pend;
            bus.ex_ready = rdy;
            bus.flush    = fl;
            drive_back(exm_m, wb_m);

            @(negedge clk);
            haz = (q.size() != 0) && q[0].mr && (q[0].rd != 0) &&
                  (pend.rs1 == q[0].rd || pend.rs2 == q[0].rd);
            exp_rdy = ((q.size() == 0) || rdy) && !haz && !fl;
            chk("rnd_id_ready", bus.id_ready, exp_rdy);
            chk("rnd_ex_valid", bus.ex_valid, q.size() != 0);
            if (q.size() != 0) begin
                s = q[0];
                a = s.a_pc ? s.pc : prog_val(s.rs1);
                b = s.b_imm ? s.imm : prog_val(s.rs2);
                if (s.ctrl == ALU_SLL || s.ctrl == ALU_SRL || s.ctrl == ALU_SRS) b = b % 32;
                chk("rnd_alu_x", bus.alu_x, a);
                chk("rnd_alu_y", bus.alu_y, b);
                chk("rnd_alu_ctrl", bus.alu_ctrl, s.ctrl);
                chk("rnd_store", bus.ex_store_data, prog_val(s.rs2));
                chk("rnd_pc", bus.ex_pc, s.pc);
                chk("rnd_rd_ctl", {bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write},
                    {s.rd, s.rw, s.mr, s.mw});
                hit = exm_m.v && exm_m.rw && exm_m.mr &&
                      ((exm_m.rd == s.rs1 && s.rs1 != 0) || (exm_m.rd == s.rs2 && s.rs2 != 0));
                chk("rnd_no_exm_load_fwd", hit, 0);
            end
            fire = (q.size() != 0) && rdy && !fl;
            acc  = have_pend && exp_rdy;

            @(posedge clk); #1;
            nxt = '0;
            if (fl) begin
                q.delete();
                have_pend = 0;
            end else begin
                if (fire) begin
                    s   = q.pop_front();
                    res = $urandom;
                    nxt = '{v: 1, rw: s.rw, mr: s.mr, rd: s.rd, res: res, junk: $urandom};
                    if (s.rw && s.rd != 0) prog[s.rd] = res;
                end
                if (acc) begin
                    q.push_back(pend);
                    have_pend = 0;
                end
            end
            if (rdy) begin
                if (wb_m.v && wb_m.rw && wb_m.rd != 0) arch[wb_m.rd] = wb_m.res;
                wb_m  = exm_m;
                exm_m = nxt;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
